// File: rtl/editor_hora_bcd.sv
// Time editor for the RTC: turns debounced button levels into BCD hh:mm:ss edits and
// issues one write strobe when programming mode ends. Optional auto-repeat: AUTOREPETICION_EN.
module editor_hora_bcd #(
    parameter int RETARDO_REP = 50_000_000,
    parameter int PERIODO_REP = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       modo_prog,
    input  logic       aumento,
    input  logic       disminuye,
    input  logic       derecha,
    input  logic       izquierda,
    input  logic [7:0] hora_in,
    input  logic [7:0] min_in,
    input  logic [7:0] seg_in,
    output logic [7:0] hora,
    output logic [7:0] min,
    output logic [7:0] seg,
    output logic [1:0] campo_sel,
    output logic       editando,
    output logic       escribir,
    output logic [1:0] estado_dbg
);

    // No handshake: buttons are levels, escribir is a one-cycle strobe the bus side must take.
    typedef enum logic [1:0] {
        INACTIVO = 2'd0,
        EDITAR   = 2'd1,
        ESCRIBIR = 2'd2
    } estado_t;

    estado_t estado, estado_sig;

    logic prev_aum, prev_dis, prev_der, prev_izq;
    logic pulso_aum, pulso_dis, pulso_der, pulso_izq;
    logic act_aum, act_dis;
    logic edicion;
    logic [7:0] campo_val, campo_max, campo_nuevo;

    if (RETARDO_REP < 1 || PERIODO_REP < 1) begin : g_chk_param
        $error("RETARDO_REP and PERIODO_REP must be positive");
    end

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] maximo);
        if (v == maximo)          return 8'h00;
        else if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
        else                      return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] maximo);
        if (v == 8'h00)           return maximo;
        else if (v[3:0] == 4'd0)  return {v[7:4] - 4'd1, 4'd9};
        else                      return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Units digit valid and whole value within range implies the tens digit is valid too.
    function automatic logic [7:0] bcd_limpio(input logic [7:0] v, input logic [7:0] maximo);
        if ((v[3:0] <= 4'd9) && (v <= maximo)) return v;
        else                                   return 8'h00;
    endfunction

    assign pulso_aum = aumento   & ~prev_aum;
    assign pulso_dis = disminuye & ~prev_dis;
    assign pulso_der = derecha   & ~prev_der;
    assign pulso_izq = izquierda & ~prev_izq;

    assign edicion = (estado == EDITAR) && modo_prog;

`ifdef AUTOREPETICION_EN
    localparam int CMAX = (RETARDO_REP > PERIODO_REP) ? RETARDO_REP : PERIODO_REP;
    localparam int CW   = $clog2(CMAX + 1);

    logic [CW-1:0] rep_cnt, rep_meta;
    logic          rep_periodo, rep_pulso, solo_uno;

    // rep_cnt counts cycles since the last action; 0 means no repeat in progress.
    assign solo_uno  = aumento ^ disminuye;
    assign rep_meta  = rep_periodo ? CW'(PERIODO_REP) : CW'(RETARDO_REP);
    assign rep_pulso = edicion && solo_uno && (rep_cnt != '0) && (rep_cnt == rep_meta);

    always_ff @(posedge clk) begin
        if (reset || !(edicion && solo_uno)) begin
            rep_cnt     <= '0;
            rep_periodo <= 1'b0;
        end else if (aumento ? pulso_aum : pulso_dis) begin
            rep_cnt     <= CW'(1);
            rep_periodo <= 1'b0;
        end else if (rep_pulso) begin
            rep_cnt     <= CW'(1);
            rep_periodo <= 1'b1;
        end else if (rep_cnt != '0) begin
            rep_cnt     <= rep_cnt + CW'(1);
        end
    end

    assign act_aum = pulso_aum | (rep_pulso & aumento);
    assign act_dis = pulso_dis | (rep_pulso & disminuye);
`else
    assign act_aum = pulso_aum;
    assign act_dis = pulso_dis;
`endif

    always_comb begin
        campo_val = hora;
        campo_max = 8'h23;
        case (campo_sel)
            2'd1:    begin campo_val = min; campo_max = 8'h59; end
            2'd2:    begin campo_val = seg; campo_max = 8'h59; end
            default: begin campo_val = hora; campo_max = 8'h23; end
        endcase
        campo_nuevo = act_aum ? bcd_inc(campo_val, campo_max) : bcd_dec(campo_val, campo_max);
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            INACTIVO: if (modo_prog)  estado_sig = EDITAR;
            EDITAR:   if (!modo_prog) estado_sig = ESCRIBIR;
            ESCRIBIR: estado_sig = INACTIVO;
            default:  estado_sig = INACTIVO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado   <= INACTIVO;
            prev_aum <= 1'b0;
            prev_dis <= 1'b0;
            prev_der <= 1'b0;
            prev_izq <= 1'b0;
        end else begin
            estado   <= estado_sig;
            prev_aum <= aumento;
            prev_dis <= disminuye;
            prev_der <= derecha;
            prev_izq <= izquierda;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hora      <= 8'h00;
            min       <= 8'h00;
            seg       <= 8'h00;
            campo_sel <= 2'd0;
        end else if (estado == INACTIVO && modo_prog) begin
            hora      <= bcd_limpio(hora_in, 8'h23);
            min       <= bcd_limpio(min_in, 8'h59);
            seg       <= bcd_limpio(seg_in, 8'h59);
            campo_sel <= 2'd0;
        end else if (edicion) begin
            // Value edit targets the field selected before this cycle's field move.
            if (act_aum ^ act_dis) begin
                case (campo_sel)
                    2'd0:    hora <= campo_nuevo;
                    2'd1:    min  <= campo_nuevo;
                    2'd2:    seg  <= campo_nuevo;
                    default: ;
                endcase
            end
            if (pulso_der && !pulso_izq)
                campo_sel <= (campo_sel == 2'd2) ? 2'd0 : campo_sel + 2'd1;
            else if (pulso_izq && !pulso_der)
                campo_sel <= (campo_sel == 2'd0) ? 2'd2 : campo_sel - 2'd1;
        end
    end

    assign editando   = (estado == EDITAR);
    assign escribir   = (estado == ESCRIBIR);
    assign estado_dbg = estado;

endmodule

// File: doc/editor_hora_bcd.md
# editor_hora_bcd

- Sits directly downstream of the push-button debouncers in the RTC controller.
- Consumes their debounced level outputs and turns them into one-cycle edit actions.
- Edits a BCD hours/minutes/seconds image while programming mode is active.
- On leaving programming mode, issues a single write strobe so the RTC bus interface can store the edited time.

## Interface
- RETARDO_REP, 50_000_000: cycles a held up/down button must stay high before auto-repeat starts.
- PERIODO_REP, 10_000_000: cycles between auto-repeat steps.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- modo_prog  input  1  level; high = programming mode requested.
- aumento  input  1  debounced level, increment selected field.
- disminuye  input  1  debounced level, decrement selected field.
- derecha  input  1  debounced level, select next field.
- izquierda  input  1  debounced level, select previous field.
- hora_in, min_in, seg_in  input  8 each  current RTC time, packed BCD.
- hora, min, seg  output  8 each  edited time, packed BCD, registered.
- campo_sel  output  2  selected field: 0 hours, 1 minutes, 2 seconds.
- editando  output  1  high while in EDITAR.
- escribir  output  1  one-cycle write strobe.

## Operation
- **Edge detection.** One previous-value register per button, updated every cycle in every state.
  - Action pulse = level high AND previous low.
  - A button already held on entry to EDITAR produces no action.
- **INACTIVO.**
  - On modo_prog sampled 1: load hora_in/min_in/seg_in, set campo_sel=0, go to EDITAR.
  - On load, any field that is not valid BCD in range is replaced by 00. Ranges: hours 00–23; min/seg 00–59.
- **EDITAR.**
  - aumento pulse: selected field +1, BCD. Wraps 23→00 for hours, 59→00 for min/seg. Units 9→0 carries into tens.
  - disminuye pulse: selected field −1. Wraps 00→23 for hours, 00→59 for min/seg. Units 0→9 borrows from tens.
  - derecha: campo_sel 0→1→2→0. izquierda: 0→2→1→0.
  - aumento and disminuye pulsing in the same cycle: both ignored. derecha and izquierda in the same cycle: both ignored.
  - Value pulse and field pulse in the same cycle: the value change applies to the old campo_sel, and campo_sel updates in that same cycle.
  - On modo_prog sampled 0: go to ESCRIBIR. Any button pulse in that cycle is ignored.
- **ESCRIBIR.**
  - escribir=1 for exactly one cycle; hora/min/seg held stable.
  - Next state is INACTIVO unconditionally, even if modo_prog is already 1 again.
  - No edits in this state.
- Outputs hold their last values in INACTIVO.

## Timing
- Reset values: hora=min=seg=8'h00, campo_sel=0, editando=0, escribir=0, state INACTIVO, edge registers 0, repeat counter 0.
- Entry: modo_prog first sampled 1 at edge k → loaded values and editando=1 visible after edge k.
- Edit latency: a button level first sampled 1 at edge k → new value/field visible after edge k.
- Exit: modo_prog sampled 0 at edge k → escribir high between edges k and k+1. editando=0 after edge k.
- Minimum programming session is one cycle in EDITAR.
- Reset asserted in any state (including ESCRIBIR): all reset values at the next edge. No escribir pulse is issued.

## Configuration
- Macro AUTOREPETICION_EN.
- **Defined:** in EDITAR, while exactly one of aumento/disminuye stays high, extra action pulses are generated.
  - Initial edge pulse at edge k.
  - Repeat pulses at edges k+RETARDO_REP, then every PERIODO_REP cycles.
  - Releasing the button, pressing the other one, or leaving EDITAR clears the counter.
  - Repeat pulses obey the same rules as edge pulses.
- **Not defined:** only edge pulses act. The repeat counter is not built and RETARDO_REP/PERIODO_REP are unused.

## Test plan
- Reset, then hold modo_prog=1 with hora_in=8'h23, min_in=8'h59, seg_in=8'h07 → next cycle editando=1, hora=23, min=59, seg=07, campo_sel=0.
- campo_sel=0, hora=23, one aumento press → hora=00. Then disminuye → hora=23.
- derecha press → campo_sel=1. min=59, aumento → min=00, hora unchanged. izquierda ×2 → campo_sel=2.
- Load hora_in=8'h3A, seg_in=8'h09 → hora=00. seg=09 +1 → 10. Then −1 → 09. aumento+disminuye in the same cycle → seg unchanged.
- Drop modo_prog → exactly one escribir pulse carrying the edited values, then editando=0. Assert reset in EDITAR instead → no escribir, all outputs 0.
- AUTOREPETICION_EN with RETARDO_REP=8, PERIODO_REP=4, min=00: hold aumento 20 cycles → pulses at offsets 0, 8, 12, 16, giving min=04. Without the macro: min=01.
